// File: rtl/lfsr_pipe_checker_pkg.sv
// Shared definitions for the LFSR/counter pattern checker: mode encodings,
// FSM state encodings and the LFSR feedback taps (31, 21, 1, 0).
package lfsr_pipe_checker_pkg;

  localparam logic MODE_LFSR    = 1'b0;
  localparam logic MODE_COUNTER = 1'b1;

  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_LO = 3'd1,
    ST_SYNC_HI = 3'd2,
    ST_CHK_LO  = 3'd3,
    ST_CHK_HI  = 3'd4
  } state_t;

  // Feedback bit shifted into bit 0 of the Fibonacci LFSR
  function automatic logic lfsr_fb(input logic [31:0] v);
    return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr_pipe_checker_next.sv
// Combinational next-value function of the pattern sequence, shared by the
// generator and the checker so both ends step the sequence identically.
module lfsr_pipe_next
  import lfsr_pipe_checker_pkg::*;
(
  input  logic [31:0] i_v,
  input  logic        i_mode,
  output logic [31:0] o_next
);

  // Counter mode increments; LFSR mode shifts left with the tap XOR in bit 0.
  // An all-zero LFSR value maps to zero, which is intentional.
  always_comb begin
    if (i_mode == MODE_COUNTER) begin
      o_next = i_v + 32'd1;
    end else begin
      o_next = {i_v[30:0], lfsr_fb(i_v)};
    end
  end

endmodule

// File: rtl/lfsr_pipe_checker.sv
// Receives the host's 16-bit pipe words (low half first), regenerates the
// expected 32-bit pattern and keeps word/error statistics for readback.
module lfsr_pipe_checker
  import lfsr_pipe_checker_pkg::*;
#(
  parameter int SELF_SYNC = 1,
  parameter int ERR_W     = 16
) (
  input  logic             ti_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      seed,
  input  logic             pipe_write,
  input  logic [15:0]      pipe_data,
  output logic             synced,
  output logic [31:0]      word_count,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag,
  output logic [31:0]      first_err_idx,
  output logic [15:0]      last_bad_word
);

  state_t             r_state;
  logic               r_mode;
  logic [31:0]        r_exp;
  logic [15:0]        r_lo;
  logic               r_synced;
  logic [31:0]        r_word_count;
  logic [ERR_W-1:0]   r_err_count;
  logic               r_err_flag;
  logic [31:0]        r_first_err_idx;
  logic [15:0]        r_last_bad_word;

  logic [31:0]        w_next_in;
  logic [31:0]        w_next;
  logic [15:0]        w_exp_half;
  logic               w_chk;
  logic               w_mismatch;

  // Error counter sticks at all-ones instead of wrapping
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // One next-function instance serves both the seeding step and the
  // per-value advance, since those happen in mutually exclusive states.
  assign w_next_in = (r_state == ST_SYNC_HI) ? {pipe_data, r_lo} : r_exp;

  lfsr_pipe_next u_next (
    .i_v    (w_next_in),
    .i_mode (r_mode),
    .o_next (w_next)
  );

  assign w_exp_half = (r_state == ST_CHK_HI) ? r_exp[31:16] : r_exp[15:0];
  assign w_chk      = pipe_write && ((r_state == ST_CHK_LO) || (r_state == ST_CHK_HI));
  assign w_mismatch = w_chk && (pipe_data != w_exp_half);

  // Checker FSM and statistics; reset beats start, start beats a same-cycle write
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_mode          <= MODE_LFSR;
      r_exp           <= '0;
      r_lo            <= '0;
      r_synced        <= 1'b0;
      r_word_count    <= '0;
      r_err_count     <= '0;
      r_err_flag      <= 1'b0;
      r_first_err_idx <= '0;
      r_last_bad_word <= '0;
    end else if (start) begin
      r_mode          <= mode;
      r_word_count    <= '0;
      r_err_count     <= '0;
      r_err_flag      <= 1'b0;
      r_first_err_idx <= '0;
      r_last_bad_word <= '0;
      if (SELF_SYNC != 0) begin
        r_state  <= ST_SYNC_LO;
        r_synced <= 1'b0;
      end else begin
        r_state  <= ST_CHK_LO;
        r_exp    <= seed;
        r_synced <= 1'b1;
      end
    end else if (pipe_write) begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SYNC_LO: begin
          r_lo         <= pipe_data;
          r_word_count <= r_word_count + 32'd1;
          r_state      <= ST_SYNC_HI;
        end
        ST_SYNC_HI: begin
          r_exp        <= w_next;
          r_synced     <= 1'b1;
          r_word_count <= r_word_count + 32'd1;
          r_state      <= ST_CHK_LO;
        end
        ST_CHK_LO: begin
          r_word_count <= r_word_count + 32'd1;
          r_state      <= ST_CHK_HI;
        end
        ST_CHK_HI: begin
          r_exp        <= w_next;
          r_word_count <= r_word_count + 32'd1;
          r_state      <= ST_CHK_LO;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // The expected sequence keeps running after a mismatch, so a single
      // corrupt word costs exactly one error.
      if (w_mismatch) begin
        r_err_count     <= sat_inc(r_err_count);
        r_last_bad_word <= pipe_data;
        if (!r_err_flag) begin
          r_err_flag      <= 1'b1;
          r_first_err_idx <= r_word_count;
        end
      end
    end
  end

  assign synced        = r_synced;
  assign word_count    = r_word_count;
  assign err_count     = r_err_count;
  assign err_flag      = r_err_flag;
  assign first_err_idx = r_first_err_idx;
  assign last_bad_word = r_last_bad_word;

endmodule

// File: tb/tb_lfsr_pipe_checker.sv
// Scoreboard bench for lfsr_pipe_checker. Instance 0: SELF_SYNC=1, ERR_W=16.
// Instance 1: SELF_SYNC=0, ERR_W=4.
module tb_lfsr_pipe_checker;

  typedef struct packed {
    logic        syn;
    logic [31:0] wc;
    logic [15:0] ec;
    logic        flag;
    logic [31:0] fidx;
    logic [15:0] last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        st[2];
  logic        wr_s[2];
  logic        rs[2];
  logic        md[2];
  logic [31:0] sd[2];
  logic [15:0] pd[2];

  logic        syn[2];
  logic [31:0] wc[2];
  logic        flg[2];
  logic [31:0] fi[2];
  logic [15:0] lb[2];
  logic [15:0] ec0;
  logic [3:0]  ec1;

  int n_chk = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic obs[2];

  lfsr_pipe_checker #(.SELF_SYNC(1), .ERR_W(16)) dut_a (
    .ti_clk(clk), .reset(rs[0]), .start(st[0]), .mode(md[0]), .seed(sd[0]),
    .pipe_write(wr_s[0]), .pipe_data(pd[0]), .synced(syn[0]), .word_count(wc[0]),
    .err_count(ec0), .err_flag(flg[0]), .first_err_idx(fi[0]), .last_bad_word(lb[0])
  );

  lfsr_pipe_checker #(.SELF_SYNC(0), .ERR_W(4)) dut_b (
    .ti_clk(clk), .reset(rs[1]), .start(st[1]), .mode(md[1]), .seed(sd[1]),
    .pipe_write(wr_s[1]), .pipe_data(pd[1]), .synced(syn[1]), .word_count(wc[1]),
    .err_count(ec1), .err_flag(flg[1]), .first_err_idx(fi[1]), .last_bad_word(lb[1])
  );

  // Reference model state, one slot per instance
  int          m_st[2];
  logic        m_mode[2];
  logic [31:0] m_exp[2];
  logic [15:0] m_lo[2];
  logic        m_syn[2];
  logic [31:0] m_wc[2];
  int          m_ec[2];
  logic        m_flag[2];
  logic [31:0] m_fidx[2];
  logic [15:0] m_last[2];

  function automatic logic [31:0] ref_next(input logic [31:0] v, input logic m);
    logic [31:0] taps;
    taps = 32'h8020_0003;
    if (m) return v + 32'd1;
    return {v[30:0], ^(v & taps)};
  endfunction

  task automatic model_cmp(input int d, input logic [15:0] data, input logic [15:0] want);
    int emax;
    emax = (d == 0) ? 65535 : 15;
    if (data != want) begin
      if (m_ec[d] < emax) m_ec[d] = m_ec[d] + 1;
      m_last[d] = data;
      if (!m_flag[d]) begin
        m_flag[d] = 1'b1;
        m_fidx[d] = m_wc[d];
      end
    end
  endtask

  task automatic model_clear(input int d);
    m_syn[d] = 1'b0; m_wc[d] = '0; m_ec[d] = 0;
    m_flag[d] = 1'b0; m_fidx[d] = '0; m_last[d] = '0;
  endtask

  task automatic model(input int d, input logic s, input logic w, input logic r,
                       input logic [15:0] data, input logic m, input logic [31:0] sv);
    if (r) begin
      model_clear(d);
      m_st[d] = 0; m_exp[d] = '0; m_mode[d] = 1'b0;
    end else if (s) begin
      model_clear(d);
      m_mode[d] = m;
      if (d == 0) m_st[d] = 1;
      else begin
        m_st[d] = 3; m_exp[d] = sv; m_syn[d] = 1'b1;
      end
    end else if (w) begin
      case (m_st[d])
        1: begin m_lo[d] = data; m_wc[d] = m_wc[d] + 1; m_st[d] = 2; end
        2: begin
          m_exp[d] = ref_next({data, m_lo[d]}, m_mode[d]);
          m_syn[d] = 1'b1; m_wc[d] = m_wc[d] + 1; m_st[d] = 3;
        end
        3: begin
          model_cmp(d, data, m_exp[d][15:0]);
          m_wc[d] = m_wc[d] + 1; m_st[d] = 4;
        end
        4: begin
          model_cmp(d, data, m_exp[d][31:16]);
          m_exp[d] = ref_next(m_exp[d], m_mode[d]);
          m_wc[d] = m_wc[d] + 1; m_st[d] = 3;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs on instance d and queue the expected response
  task automatic step(input int d, input logic s, input logic w, input logic r,
                      input logic [15:0] data, input logic m, input logic [31:0] sv);
    exp_t e;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; wr_s[k] = 1'b0; rs[k] = 1'b0;
    end
    st[d] = s; wr_s[d] = w; rs[d] = r; pd[d] = data; md[d] = m; sd[d] = sv;
    model(d, s, w, r, data, m, sv);
    e.syn = m_syn[d]; e.wc = m_wc[d]; e.ec = 16'(m_ec[d]); e.flag = m_flag[d];
    e.fidx = m_fidx[d]; e.last = m_last[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wr(input int d, input logic [15:0] data);
    step(d, 1'b0, 1'b1, 1'b0, data, md[d], sd[d]);
  endtask

  task automatic put32(input int d, input logic [31:0] v);
    wr(d, v[15:0]);
    wr(d, v[31:16]);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; wr_s[k] = 1'b0; rs[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) obs[d] <= st[d] | wr_s[d] | rs[d];
  end

  // Monitor: every consumed input cycle yields one response to compare
  always @(negedge clk) begin : mon
    exp_t a;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (obs[d] === 1'b1) begin
        a.syn = syn[d]; a.wc = wc[d]; a.ec = (d == 0) ? ec0 : {12'h000, ec1};
        a.flag = flg[d]; a.fidx = fi[d]; a.last = lb[d];
        n_chk++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_err++;
          $display("FAIL sb%0d: response with empty expectation queue", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL sb%0d: got syn=%0d wc=%0d ec=%0d flag=%0d fidx=%0d last=%h, expected syn=%0d wc=%0d ec=%0d flag=%0d fidx=%0d last=%h",
                     d, a.syn, a.wc, a.ec, a.flag, a.fidx, a.last,
                     e.syn, e.wc, e.ec, e.flag, e.fidx, e.last);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; wr_s[k] = 1'b0; rs[k] = 1'b0; md[k] = 1'b0; sd[k] = '0; pd[k] = '0;
    end

    // Reset state of both instances
    step(0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0);
    step(1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0);
    idle();
    chk("rst wc", wc[0], 32'd0);
    chk("rst synced", {31'd0, syn[0]}, 32'd0);
    chk("rst b synced", {31'd0, syn[1]}, 32'd0);

    // Case 1: counter, self-synchronising
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0);
    wr(0, 16'h0000); wr(0, 16'h0000); wr(0, 16'h0001);
    wr(0, 16'h0000); wr(0, 16'h0002); wr(0, 16'h0000);
    idle();
    chk("t1 synced", {31'd0, syn[0]}, 32'd1);
    chk("t1 wc", wc[0], 32'd6);
    chk("t1 ec", {16'd0, ec0}, 32'd0);

    // Case 3: counter with word 5 corrupted, later words must pass
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0);
    wr(0, 16'h0000); wr(0, 16'h0000); wr(0, 16'h0001);
    wr(0, 16'h0000); wr(0, 16'h0002); wr(0, 16'h1234);
    wr(0, 16'h0003); wr(0, 16'h0000);
    idle();
    chk("t3 ec", {16'd0, ec0}, 32'd1);
    chk("t3 flag", {31'd0, flg[0]}, 32'd1);
    chk("t3 fidx", fi[0], 32'd5);
    chk("t3 last", {16'd0, lb[0]}, 32'h1234);
    chk("t3 wc", wc[0], 32'd8);

    // Case 4: 512 back-to-back LFSR words, then start collides with a write
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    v = 32'hC0FF_EE01;
    for (int i = 0; i < 256; i++) begin
      put32(0, v);
      v = ref_next(v, 1'b0);
    end
    step(0, 1'b1, 1'b1, 1'b0, v[15:0], 1'b0, 32'h0);
    idle();
    chk("t4 wc after restart", wc[0], 32'd0);
    chk("t4 ec after restart", {16'd0, ec0}, 32'd0);
    chk("t4 synced after restart", {31'd0, syn[0]}, 32'd0);

    // Case 5: reset after word 3, following words ignored, start re-arms
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0);
    wr(0, 16'h0000); wr(0, 16'h0000); wr(0, 16'h0001);
    step(0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0);
    wr(0, 16'h0000); wr(0, 16'h0002); wr(0, 16'h0000); wr(0, 16'h0003);
    idle();
    chk("t5 wc after reset", wc[0], 32'd0);
    chk("t5 synced after reset", {31'd0, syn[0]}, 32'd0);
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0);
    put32(0, 32'h0000_0005); put32(0, 32'h0000_0006);
    idle();
    chk("t5 rearm wc", wc[0], 32'd4);
    chk("t5 rearm synced", {31'd0, syn[0]}, 32'd1);
    chk("t5 rearm ec", {16'd0, ec0}, 32'd0);

    // Case 2: LFSR from seed port, seed 1
    step(1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0000_0001);
    wr(1, 16'h0001); wr(1, 16'h0000); wr(1, 16'h0003); wr(1, 16'h0000);
    wr(1, 16'h0006); wr(1, 16'h0000); wr(1, 16'h000D); wr(1, 16'h0000);
    idle();
    chk("t2 wc", wc[1], 32'd8);
    chk("t2 ec", {28'd0, ec1}, 32'd0);
    chk("t2 synced", {31'd0, syn[1]}, 32'd1);

    // Case 6: 4-bit error counter saturates
    step(1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 20; i++) wr(1, 16'hFFFF);
    idle();
    chk("t6 ec sat", {28'd0, ec1}, 32'hF);
    chk("t6 wc", wc[1], 32'd20);
    chk("t6 fidx", fi[1], 32'd0);
    chk("t6 last", {16'd0, lb[1]}, 32'hFFFF);

    repeat (3) @(negedge clk);
    chk("sb0 drained", q0.size(), 32'd0);
    chk("sb1 drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
